rtc_bus_arbiter: RTL and testbench
==================================

# rtc_bus_arbiter

Fixed-priority arbiter and scheduler for the shared RTC parallel bus (a_d, cs, rd, wr, data-buffer enable). It serves three bus sequencers: initialisation, write and read. It grants the bus to one sequencer at a time, pulses that sequencer's start input, and muxes the granted sequencer's control lines onto the pins. It also generates a periodic auto-read request and aborts any transaction that overruns a watchdog.

## Interface
- PERIOD, 1000: auto-read interval in clk cycles; legal range 2..2^20-1.
- TIMEOUT, 1023: watchdog limit in clk cycles per transaction; legal range 2..2^20-1.
- GUARD, 4: number of idle bus cycles inserted after every transaction; legal range 1..15.

Clock and reset (already decided): one clock, `clk`; reset is synchronous and active-high, `reset`.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_init, req_escr, req_lect  in  1 each  one-cycle request pulses
- auto_en  in  1  enables the periodic auto-read timer
- done_init, done_escr, done_lect  in  1 each  sequencer completion pulses
- a_d_init/cs_init/rd_init/wr_init/buf_init  in  1 each  init sequencer bus signals
- a_d_escr/cs_escr/rd_escr/wr_escr/buf_escr  in  1 each  write sequencer bus signals
- a_d_lect/cs_lect/rd_lect/wr_lect/buf_lect  in  1 each  read sequencer bus signals
- start_init, start_escr, start_lect  out  1 each  one-cycle start pulses
- gnt_init, gnt_escr, gnt_lect  out  1 each  grant, one-hot or all zero
- a_d, cs, rd, wr  out  1 each  RTC pins, active-low, idle level 1
- buffer_activo  out  1  tri-state data buffer enable, idle level 0
- busy  out  1  asserted whenever state is not IDLE
- owner  out  2  current owner: 00 none, 01 init, 10 escr, 11 lect
- err_timeout  out  1  one-cycle pulse when the watchdog aborts a transaction

## Operation
- **Pending flags.** pend_init, pend_escr and pend_lect are set by their req_x pulse. pend_lect is also set by an auto-read tick.
  - A flag is cleared on the edge that enters START for that requester.
  - A req_x arriving on that same edge leaves the flag set (the new request is kept).
  - Repeated requests while a flag is already set merge into one.
- **Auto timer.** A 20-bit counter runs while auto_en=1 and holds at 0 while auto_en=0. At PERIOD-1 it wraps to 0 and sets pend_lect. It keeps counting during transactions.
- **Priority.** init > escr > lect, evaluated only in IDLE. The arbiter is non-preemptive.
- **State machine:**
  - IDLE: if any flag is set, latch the winner into owner and go to START.
  - START (1 cycle): start_x=1 and gnt_x=1; go to BUSY.
  - BUSY: gnt_x held. The watchdog counts from 0.
    - done from the owner goes to GUARD.
    - Watchdog reaching TIMEOUT-1 with no done goes to GUARD and pulses err_timeout.
    - done from a non-owner is ignored.
  - GUARD: all grants 0, pins at idle levels, count GUARD cycles, then go to IDLE. owner returns to 00 on entry to GUARD.
- **Bus mux.** In START and BUSY the pins and buffer_activo follow the owner's inputs combinationally. In every other state they are forced to a_d=cs=rd=wr=1 and buffer_activo=0.
- **Reset** (synchronous, valid mid-transaction):
  - State goes to IDLE; flags, timer, watchdog and guard counters go to 0.
  - Output values: all start/gnt 0, pins at idle levels, busy=0, owner=00, err_timeout=0.
  - Requests sampled in the reset cycle are dropped.

## Timing
- From IDLE, a req_x sampled at edge n sets its flag at n. START is entered at n+1, so start_x and gnt_x are high in the cycle after edge n+1 (2-cycle latency).
- The done_x sampled at edge m moves to GUARD at m. gnt_x drops in the cycle after edge m.
- A back-to-back pending request gets its next start_x exactly GUARD+1 cycles after GUARD is entered.
- Timeout: err_timeout is high for exactly the one cycle after the edge where the watchdog equals TIMEOUT-1. This is TIMEOUT cycles after entering BUSY.
- done_x coinciding with the timeout edge counts as completion: no err_timeout.
- Flags set while busy, or simultaneous requests, are served in priority order, one transaction each.

## Test plan
- **Single read:** reset, then req_lect=1 at cycle 5 → start_lect high at cycle 7, gnt_lect=1, owner=11. Pins follow the lect inputs until done_lect at cycle 40, then idle for 4 cycles and busy=0 at cycle 45.
- **Priority:** req_lect, req_escr and req_init pulsed together → served init, escr, lect in that order, each start separated by GUARD+1 cycles after the previous done.
- **Auto-read:** auto_en=1 with PERIOD=10 and no requests → pend_lect set every 10 cycles. A req_lect in the same cycle as a tick produces one transaction only.
- **Timeout:** grant escr and never assert done_escr → err_timeout pulses once after TIMEOUT cycles, then guard, then IDLE. A stray done_lect during BUSY is ignored.
- **Reset mid-BUSY:** assert reset during an init transaction with escr pending → next cycle all grants 0, pins 1/1/1/1, buffer_activo=0, flags cleared, no start on release.

Source files
------------

// File: rtl/rtc_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// rtc_bus_arbiter_if
// Bundles every handshake and bus signal between the RTC bus arbiter and the
// three bus sequencers (init, escr = write, lect = read) plus the RTC pins.
//
//   requests   : req_init, req_escr, req_lect, auto_en      (to arbiter)
//   completion : done_init, done_escr, done_lect            (to arbiter)
//   seq buses  : a_d/cs/rd/wr/buf_{init,escr,lect}          (to arbiter)
//   control    : start_*, gnt_*                             (from arbiter)
//   RTC pins   : a_d, cs, rd, wr (active-low), buffer_activo (from arbiter)
//   status     : busy, owner[1:0], err_timeout              (from arbiter)
//
// Modport master is the arbiter side, slave is the sequencer/pin side.
// ---------------------------------------------------------------------------
interface rtc_bus_arbiter_if;
    logic       req_init;
    logic       req_escr;
    logic       req_lect;
    logic       auto_en;
    logic       done_init;
    logic       done_escr;
    logic       done_lect;
    logic       a_d_init;
    logic       cs_init;
    logic       rd_init;
    logic       wr_init;
    logic       buf_init;
    logic       a_d_escr;
    logic       cs_escr;
    logic       rd_escr;
    logic       wr_escr;
    logic       buf_escr;
    logic       a_d_lect;
    logic       cs_lect;
    logic       rd_lect;
    logic       wr_lect;
    logic       buf_lect;
    logic       start_init;
    logic       start_escr;
    logic       start_lect;
    logic       gnt_init;
    logic       gnt_escr;
    logic       gnt_lect;
    logic       a_d;
    logic       cs;
    logic       rd;
    logic       wr;
    logic       buffer_activo;
    logic       busy;
    logic [1:0] owner;
    logic       err_timeout;

    modport master (
        input  req_init, req_escr, req_lect, auto_en,
        input  done_init, done_escr, done_lect,
        input  a_d_init, cs_init, rd_init, wr_init, buf_init,
        input  a_d_escr, cs_escr, rd_escr, wr_escr, buf_escr,
        input  a_d_lect, cs_lect, rd_lect, wr_lect, buf_lect,
        output start_init, start_escr, start_lect,
        output gnt_init, gnt_escr, gnt_lect,
        output a_d, cs, rd, wr, buffer_activo,
        output busy, owner, err_timeout
    );

    modport slave (
        output req_init, req_escr, req_lect, auto_en,
        output done_init, done_escr, done_lect,
        output a_d_init, cs_init, rd_init, wr_init, buf_init,
        output a_d_escr, cs_escr, rd_escr, wr_escr, buf_escr,
        output a_d_lect, cs_lect, rd_lect, wr_lect, buf_lect,
        input  start_init, start_escr, start_lect,
        input  gnt_init, gnt_escr, gnt_lect,
        input  a_d, cs, rd, wr, buffer_activo,
        input  busy, owner, err_timeout
    );
endinterface

// File: rtl/rtc_bus_arbiter.sv
// ---------------------------------------------------------------------------
// rtc_bus_arbiter
// Fixed-priority (init > escr > lect), non-preemptive arbiter for the shared
// RTC parallel bus. Latches requests into pending flags, grants one sequencer
// at a time with a one-cycle start pulse, muxes the owner's bus lines onto the
// RTC pins, inserts GUARD idle cycles after each transaction, raises a
// periodic auto-read request and aborts transactions that overrun TIMEOUT.
//
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   bus    : rtc_bus_arbiter_if.master (requests, done pulses, sequencer
//            bus lines in; start/grant, RTC pins, busy/owner/err_timeout out)
//
// Parameters:
//   PERIOD  : auto-read interval in clk cycles (2..2^20-1)
//   TIMEOUT : watchdog limit per transaction in clk cycles (2..2^20-1)
//   GUARD   : idle bus cycles after every transaction (1..15)
// ---------------------------------------------------------------------------
module rtc_bus_arbiter #(
    parameter int unsigned PERIOD  = 1000,
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned GUARD   = 4
) (
    input  logic              clk,
    input  logic              reset,
    rtc_bus_arbiter_if.master bus
);

    localparam logic [19:0] PERIOD_LAST  = 20'(PERIOD - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT - 1);
    localparam logic [3:0]  GUARD_LAST   = 4'(GUARD - 1);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_INIT = 2'b01;
    localparam logic [1:0] OWN_ESCR = 2'b10;
    localparam logic [1:0] OWN_LECT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_BUSY  = 2'b10,
        ST_GUARD = 2'b11
    } state_t;

    state_t      state_r;
    logic        pend_init_r;
    logic        pend_escr_r;
    logic        pend_lect_r;
    logic [19:0] auto_cnt_r;
    logic [19:0] wd_cnt_r;
    logic [3:0]  guard_cnt_r;
    logic [1:0]  owner_r;
    logic        start_init_r;
    logic        start_escr_r;
    logic        start_lect_r;
    logic        gnt_init_r;
    logic        gnt_escr_r;
    logic        gnt_lect_r;
    logic        busy_r;
    logic        err_timeout_r;

    logic        auto_tick_s;
    logic [1:0]  winner_s;
    logic        enter_start_s;
    logic        clr_init_s;
    logic        clr_escr_s;
    logic        clr_lect_s;
    logic        owner_done_s;
    logic [4:0]  pins_s;

    // Auto-read timer: free-runs while enabled, parked at zero otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            auto_cnt_r <= 20'd0;
        end else if (!bus.auto_en) begin
            auto_cnt_r <= 20'd0;
        end else if (auto_cnt_r == PERIOD_LAST) begin
            auto_cnt_r <= 20'd0;
        end else begin
            auto_cnt_r <= auto_cnt_r + 20'd1;
        end
    end

    assign auto_tick_s = bus.auto_en & (auto_cnt_r == PERIOD_LAST);

    // Priority pick among pending flags; only acted upon in IDLE.
    always_comb begin
        winner_s = OWN_NONE;
        if (pend_init_r) begin
            winner_s = OWN_INIT;
        end else if (pend_escr_r) begin
            winner_s = OWN_ESCR;
        end else if (pend_lect_r) begin
            winner_s = OWN_LECT;
        end else begin
            winner_s = OWN_NONE;
        end
    end

    assign enter_start_s = (state_r == ST_IDLE) & (winner_s != OWN_NONE);
    assign clr_init_s    = enter_start_s & (winner_s == OWN_INIT);
    assign clr_escr_s    = enter_start_s & (winner_s == OWN_ESCR);
    assign clr_lect_s    = enter_start_s & (winner_s == OWN_LECT);

    // Pending flags: a set on the clearing edge wins, so a fresh request
    // arriving as the previous one is granted is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_init_r <= 1'b0;
            pend_escr_r <= 1'b0;
            pend_lect_r <= 1'b0;
        end else begin
            pend_init_r <= bus.req_init | (pend_init_r & ~clr_init_s);
            pend_escr_r <= bus.req_escr | (pend_escr_r & ~clr_escr_s);
            pend_lect_r <= bus.req_lect | auto_tick_s | (pend_lect_r & ~clr_lect_s);
        end
    end

    // Completion from the current owner only; other done pulses are ignored.
    always_comb begin
        owner_done_s = 1'b0;
        case (owner_r)
            OWN_INIT: owner_done_s = bus.done_init;
            OWN_ESCR: owner_done_s = bus.done_escr;
            OWN_LECT: owner_done_s = bus.done_lect;
            default:  owner_done_s = 1'b0;
        endcase
    end

    // Arbitration FSM with registered start/grant/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            owner_r       <= OWN_NONE;
            wd_cnt_r      <= 20'd0;
            guard_cnt_r   <= 4'd0;
            start_init_r  <= 1'b0;
            start_escr_r  <= 1'b0;
            start_lect_r  <= 1'b0;
            gnt_init_r    <= 1'b0;
            gnt_escr_r    <= 1'b0;
            gnt_lect_r    <= 1'b0;
            busy_r        <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            // Start and error are single-cycle pulses by default.
            start_init_r  <= 1'b0;
            start_escr_r  <= 1'b0;
            start_lect_r  <= 1'b0;
            err_timeout_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (enter_start_s) begin
                        state_r      <= ST_START;
                        owner_r      <= winner_s;
                        wd_cnt_r     <= 20'd0;
                        busy_r       <= 1'b1;
                        start_init_r <= (winner_s == OWN_INIT);
                        start_escr_r <= (winner_s == OWN_ESCR);
                        start_lect_r <= (winner_s == OWN_LECT);
                        gnt_init_r   <= (winner_s == OWN_INIT);
                        gnt_escr_r   <= (winner_s == OWN_ESCR);
                        gnt_lect_r   <= (winner_s == OWN_LECT);
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_START: begin
                    state_r  <= ST_BUSY;
                    wd_cnt_r <= 20'd0;
                end
                ST_BUSY: begin
                    // Completion is checked before the watchdog so a done on
                    // the timeout edge is a normal finish.
                    if (owner_done_s || (wd_cnt_r == TIMEOUT_LAST)) begin
                        state_r       <= ST_GUARD;
                        owner_r       <= OWN_NONE;
                        guard_cnt_r   <= 4'd0;
                        gnt_init_r    <= 1'b0;
                        gnt_escr_r    <= 1'b0;
                        gnt_lect_r    <= 1'b0;
                        err_timeout_r <= ~owner_done_s;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + 20'd1;
                    end
                end
                ST_GUARD: begin
                    if (guard_cnt_r == GUARD_LAST) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        guard_cnt_r <= guard_cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    owner_r    <= OWN_NONE;
                    gnt_init_r <= 1'b0;
                    gnt_escr_r <= 1'b0;
                    gnt_lect_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Pin mux: owner_r is non-zero exactly in START and BUSY, so it alone
    // selects between the owner's lines and the idle levels.
    always_comb begin
        pins_s = 5'b11110;
        case (owner_r)
            OWN_INIT: pins_s = {bus.a_d_init, bus.cs_init, bus.rd_init, bus.wr_init, bus.buf_init};
            OWN_ESCR: pins_s = {bus.a_d_escr, bus.cs_escr, bus.rd_escr, bus.wr_escr, bus.buf_escr};
            OWN_LECT: pins_s = {bus.a_d_lect, bus.cs_lect, bus.rd_lect, bus.wr_lect, bus.buf_lect};
            default:  pins_s = 5'b11110;
        endcase
    end

    assign bus.a_d           = pins_s[4];
    assign bus.cs            = pins_s[3];
    assign bus.rd            = pins_s[2];
    assign bus.wr            = pins_s[1];
    assign bus.buffer_activo = pins_s[0];

    assign bus.start_init  = start_init_r;
    assign bus.start_escr  = start_escr_r;
    assign bus.start_lect  = start_lect_r;
    assign bus.gnt_init    = gnt_init_r;
    assign bus.gnt_escr    = gnt_escr_r;
    assign bus.gnt_lect    = gnt_lect_r;
    assign bus.busy        = busy_r;
    assign bus.owner       = owner_r;
    assign bus.err_timeout = err_timeout_r;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rtc_bus_arbiter
// Randomised bench for rtc_bus_arbiter. A transaction-level reference model
// (pending set, current owner, age of the transaction, guard cycles left,
// auto timer) predicts every output after each clock edge.
// ---------------------------------------------------------------------------
module tb_rtc_bus_arbiter;

    localparam int P_PERIOD  = 10;
    localparam int P_TIMEOUT = 20;
    localparam int P_GUARD   = 4;

    logic clk;
    logic reset;

    rtc_bus_arbiter_if bus ();

    rtc_bus_arbiter #(
        .PERIOD  (P_PERIOD),
        .TIMEOUT (P_TIMEOUT),
        .GUARD   (P_GUARD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks;
    int n_pass;

    // Reference model state (index 1 = init, 2 = escr, 3 = lect).
    int       m_timer;
    bit [3:1] m_pend;
    int       m_owner;
    bit       m_active;
    int       m_age;
    int       m_guard;
    bit       m_err;
    int       n_timeouts;
    int       n_starts;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [4:0] seq_pins(input int who);
        case (who)
            1:       return {bus.a_d_init, bus.cs_init, bus.rd_init, bus.wr_init, bus.buf_init};
            2:       return {bus.a_d_escr, bus.cs_escr, bus.rd_escr, bus.wr_escr, bus.buf_escr};
            3:       return {bus.a_d_lect, bus.cs_lect, bus.rd_lect, bus.wr_lect, bus.buf_lect};
            default: return 5'b11110;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs present at it.
    task automatic model_edge();
        bit [3:1] req;
        bit [3:1] done;
        bit [3:1] clr;
        bit       tick;
        bit       ending;
        req    = {bus.req_lect, bus.req_escr, bus.req_init};
        done   = {bus.done_lect, bus.done_escr, bus.done_init};
        clr    = 3'b000;
        m_err  = 1'b0;
        ending = 1'b0;
        if (reset) begin
            m_timer  = 0;
            m_pend   = 3'b000;
            m_owner  = 0;
            m_active = 1'b0;
            m_age    = 0;
            m_guard  = 0;
        end else begin
            tick    = bus.auto_en && (m_timer == P_PERIOD - 1);
            m_timer = (!bus.auto_en || tick) ? 0 : m_timer + 1;
            if (m_active) begin
                // m_age: 0 = start cycle, k >= 1 = (k-1) busy cycles elapsed
                if (m_age == 0) begin
                    m_age = 1;
                end else if (done[m_owner]) begin
                    ending = 1'b1;
                end else if (m_age == P_TIMEOUT) begin
                    ending = 1'b1;
                    m_err  = 1'b1;
                    n_timeouts++;
                end else begin
                    m_age++;
                end
            end else if (m_guard > 0) begin
                m_guard--;
            end else begin
                for (int k = 1; k <= 3; k++) begin
                    if (m_pend[k] && !m_active) begin
                        m_owner  = k;
                        m_active = 1'b1;
                        m_age    = 0;
                        clr[k]   = 1'b1;
                        n_starts++;
                    end
                end
            end
            if (ending) begin
                m_active = 1'b0;
                m_owner  = 0;
                m_guard  = P_GUARD;
            end
            m_pend = req | {tick, 2'b00} | (m_pend & ~clr);
        end
    endtask

    task automatic step(input string tag);
        logic [14:0] act;
        logic [14:0] exp;
        logic [2:0]  onehot;
        @(posedge clk);
        model_edge();
        #1;
        onehot = m_active ? (3'b100 >> (m_owner - 1)) : 3'b000;
        exp = {(m_active && m_age == 0) ? onehot : 3'b000,
               onehot,
               m_active ? seq_pins(m_owner) : 5'b11110,
               (m_active || m_guard > 0),
               m_active ? 2'(m_owner) : 2'b00,
               m_err};
        act = {bus.start_init, bus.start_escr, bus.start_lect,
               bus.gnt_init, bus.gnt_escr, bus.gnt_lect,
               bus.a_d, bus.cs, bus.rd, bus.wr, bus.buffer_activo,
               bus.busy, bus.owner, bus.err_timeout};
        check_val(tag, 32'(act), 32'(exp));
    endtask

    task automatic drive_idle_inputs();
        bus.req_init  = 1'b0;
        bus.req_escr  = 1'b0;
        bus.req_lect  = 1'b0;
        bus.done_init = 1'b0;
        bus.done_escr = 1'b0;
        bus.done_lect = 1'b0;
    endtask

    task automatic drive_random_bus();
        {bus.a_d_init, bus.cs_init, bus.rd_init, bus.wr_init, bus.buf_init} = 5'($urandom);
        {bus.a_d_escr, bus.cs_escr, bus.rd_escr, bus.wr_escr, bus.buf_escr} = 5'($urandom);
        {bus.a_d_lect, bus.cs_lect, bus.rd_lect, bus.wr_lect, bus.buf_lect} = 5'($urandom);
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        n_timeouts = 0;
        n_starts   = 0;
        m_timer    = 0;
        m_pend     = 3'b000;
        m_owner    = 0;
        m_active   = 1'b0;
        m_age      = 0;
        m_guard    = 0;
        m_err      = 1'b0;
        reset       = 1'b1;
        bus.auto_en = 1'b0;
        drive_idle_inputs();
        drive_random_bus();

        // Reset, with a request sampled during reset that must be dropped.
        bus.req_escr = 1'b1;
        step("reset0");
        step("reset1");
        reset = 1'b0;
        bus.req_escr = 1'b0;
        for (int i = 0; i < 4; i++) step("post_reset");

        // Three simultaneous requests; sequencers finish after a while.
        bus.req_init = 1'b1;
        bus.req_escr = 1'b1;
        bus.req_lect = 1'b1;
        step("prio_req");
        drive_idle_inputs();
        for (int i = 0; i < 80; i++) begin
            drive_random_bus();
            bus.done_init = (i % 12 == 11);
            bus.done_escr = (i % 12 == 11);
            bus.done_lect = (i % 12 == 11);
            step("prio");
        end
        drive_idle_inputs();

        // Auto-read alone with no done: periodic reads all time out.
        bus.auto_en = 1'b1;
        for (int i = 0; i < 120; i++) begin
            drive_random_bus();
            step("auto_timeout");
        end

        // Mid-transaction reset with a write pending.
        bus.req_escr = 1'b1;
        step("pend_escr");
        bus.req_escr = 1'b0;
        reset = 1'b1;
        step("mid_reset");
        reset = 1'b0;
        bus.auto_en = 1'b0;
        for (int i = 0; i < 6; i++) step("after_reset");

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            reset         = ($urandom_range(0, 499) == 0);
            bus.req_init  = ($urandom_range(0, 29) == 0);
            bus.req_escr  = ($urandom_range(0, 24) == 0);
            bus.req_lect  = ($urandom_range(0, 19) == 0);
            bus.done_init = ($urandom_range(0, 7) == 0);
            bus.done_escr = ($urandom_range(0, 9) == 0);
            bus.done_lect = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 149) == 0) bus.auto_en = ~bus.auto_en;
            drive_random_bus();
            step("random");
        end

        // The stimulus must actually have produced grants and watchdog aborts.
        check_val("starts_seen", 32'(n_starts > 20), 32'd1);
        check_val("timeouts_seen", 32'(n_timeouts > 2), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
